// File: rtl/cc_microseq_pkg.sv
// Shared encodings for the microsequencer: COND field, address-mux select, FSM states and
// the decode-dispatch address helper.
package cc_microseq_pkg;

  localparam int unsigned DATAWIDTH_ADDR    = 11;
  localparam int unsigned DATAWIDTH_DECODE  = 8;
  localparam int unsigned DATAWIDTH_COND    = 3;
  localparam int unsigned DATAWIDTH_MUX_SEL = 2;

  localparam logic [DATAWIDTH_COND-1:0] COND_NEXT   = 3'b000;
  localparam logic [DATAWIDTH_COND-1:0] COND_N      = 3'b001;
  localparam logic [DATAWIDTH_COND-1:0] COND_Z      = 3'b010;
  localparam logic [DATAWIDTH_COND-1:0] COND_V      = 3'b011;
  localparam logic [DATAWIDTH_COND-1:0] COND_C      = 3'b100;
  localparam logic [DATAWIDTH_COND-1:0] COND_IR13   = 3'b101;
  localparam logic [DATAWIDTH_COND-1:0] COND_ALWAYS = 3'b110;
  localparam logic [DATAWIDTH_COND-1:0] COND_DECODE = 3'b111;

  localparam logic [DATAWIDTH_MUX_SEL-1:0] MUX_SEL_NEXT   = 2'b00;
  localparam logic [DATAWIDTH_MUX_SEL-1:0] MUX_SEL_JUMP   = 2'b01;
  localparam logic [DATAWIDTH_MUX_SEL-1:0] MUX_SEL_DECODE = 2'b10;

  localparam logic [1:0] ST_START = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;

  localparam logic [DATAWIDTH_ADDR-1:0] RESET_UADDR = '0;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  // Opcode dispatch lands in the upper half of the control store, 4 words per opcode.
  function automatic logic [DATAWIDTH_ADDR-1:0] decode_addr(
    input logic [DATAWIDTH_DECODE-1:0] op
  );
    return {1'b1, op, 2'b00};
  endfunction

endpackage

// File: rtl/cc_microseq_if.sv
// Control-store / datapath side of the microsequencer, grouped as one bundle.
interface cc_microseq_if
  import cc_microseq_pkg::*;
();

  logic                         CC_MICROSEQ_hold_In;
  logic [DATAWIDTH_COND-1:0]    CC_MICROSEQ_cond_InBUS;
  logic [DATAWIDTH_ADDR-1:0]    CC_MICROSEQ_jumpAddr_InBUS;
  logic [DATAWIDTH_DECODE-1:0]  CC_MICROSEQ_decode_InBUS;
  logic [3:0]                   CC_MICROSEQ_flags_InBUS;
  logic                         CC_MICROSEQ_ir13_In;
  logic [DATAWIDTH_ADDR-1:0]    CC_MICROSEQ_microPC_OutBUS;
  logic [DATAWIDTH_MUX_SEL-1:0] CC_MICROSEQ_muxSel_OutBUS;
  logic                         CC_MICROSEQ_valid_Out;

  modport master (
    output CC_MICROSEQ_hold_In,
    output CC_MICROSEQ_cond_InBUS,
    output CC_MICROSEQ_jumpAddr_InBUS,
    output CC_MICROSEQ_decode_InBUS,
    output CC_MICROSEQ_flags_InBUS,
    output CC_MICROSEQ_ir13_In,
    input  CC_MICROSEQ_microPC_OutBUS,
    input  CC_MICROSEQ_muxSel_OutBUS,
    input  CC_MICROSEQ_valid_Out
  );

  modport slave (
    input  CC_MICROSEQ_hold_In,
    input  CC_MICROSEQ_cond_InBUS,
    input  CC_MICROSEQ_jumpAddr_InBUS,
    input  CC_MICROSEQ_decode_InBUS,
    input  CC_MICROSEQ_flags_InBUS,
    input  CC_MICROSEQ_ir13_In,
    output CC_MICROSEQ_microPC_OutBUS,
    output CC_MICROSEQ_muxSel_OutBUS,
    output CC_MICROSEQ_valid_Out
  );

endinterface

// File: rtl/cc_microseq_cond.sv
// Branch-condition evaluator: COND field against PSR flags and IR[13] -> next-address select.
module cc_microseq_cond
  import cc_microseq_pkg::*;
(
  input  logic [DATAWIDTH_COND-1:0]    cond_i,
  input  flags_t                       flags_i,
  input  logic                         ir13_i,
  output logic [DATAWIDTH_MUX_SEL-1:0] mux_sel_o
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (cond_i)
      COND_N:      taken = flags_i.n;
      COND_Z:      taken = flags_i.z;
      COND_V:      taken = flags_i.v;
      COND_C:      taken = flags_i.c;
      COND_IR13:   taken = ir13_i;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  always_comb begin
    if (cond_i == COND_DECODE) begin
      mux_sel_o = MUX_SEL_DECODE;
    end else if (taken) begin
      mux_sel_o = MUX_SEL_JUMP;
    end else begin
      mux_sel_o = MUX_SEL_NEXT;
    end
  end

endmodule

// File: rtl/cc_microsequencer.sv
// Microsequencer top: START/RUN/STALL FSM, microPC register and the 3-way next-address mux.
module cc_microsequencer
  import cc_microseq_pkg::*;
(
  input  logic         CC_MICROSEQ_CLOCK_50,
  input  logic         CC_MICROSEQ_RESET_InHigh,
  cc_microseq_if.slave seq
);

  logic [1:0]                   state_q, state_d;
  logic [DATAWIDTH_ADDR-1:0]    micro_pc_q, micro_pc_d;
  logic [DATAWIDTH_ADDR-1:0]    next_addr;
  logic [DATAWIDTH_MUX_SEL-1:0] mux_sel;
  flags_t                       flags;

  assign flags = flags_t'(seq.CC_MICROSEQ_flags_InBUS);

  cc_microseq_cond u_cond (
    .cond_i    (seq.CC_MICROSEQ_cond_InBUS),
    .flags_i   (flags),
    .ir13_i    (seq.CC_MICROSEQ_ir13_In),
    .mux_sel_o (mux_sel)
  );

  always_comb begin
    case (mux_sel)
      MUX_SEL_JUMP:   next_addr = seq.CC_MICROSEQ_jumpAddr_InBUS;
      MUX_SEL_DECODE: next_addr = decode_addr(seq.CC_MICROSEQ_decode_InBUS);
      default:        next_addr = micro_pc_q + 1'b1;
    endcase
  end

  // A hold seen in RUN freezes the microPC; the branch is re-evaluated on the resume edge.
  always_comb begin
    state_d    = state_q;
    micro_pc_d = micro_pc_q;
    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (seq.CC_MICROSEQ_hold_In) begin
          state_d = ST_STALL;
        end else begin
          micro_pc_d = next_addr;
        end
      end
      ST_STALL: begin
        if (!seq.CC_MICROSEQ_hold_In) begin
          state_d    = ST_RUN;
          micro_pc_d = next_addr;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge CC_MICROSEQ_CLOCK_50 or posedge CC_MICROSEQ_RESET_InHigh) begin
    if (CC_MICROSEQ_RESET_InHigh) begin
      state_q    <= ST_START;
      micro_pc_q <= RESET_UADDR;
    end else begin
      state_q    <= state_d;
      micro_pc_q <= micro_pc_d;
    end
  end

  assign seq.CC_MICROSEQ_microPC_OutBUS = micro_pc_q;
  assign seq.CC_MICROSEQ_muxSel_OutBUS  = mux_sel;
  assign seq.CC_MICROSEQ_valid_Out      = (state_q == ST_RUN);

endmodule
